// File: rtl/axi_multi_port_busy_tracker.sv
// Per-port outstanding AXI write/read tracker with throttling, idle-hysteresis busy and drain handshake.
// Optional completion statistics are enabled by defining AXI_BUSY_TRACKER_STATS_EN.
module axi_multi_port_busy_tracker #(
  parameter int unsigned NumPorts         = 2,
  parameter int unsigned MaxWrOutstanding = 8,
  parameter int unsigned MaxRdOutstanding = 8,
  parameter int unsigned IdleHoldCycles   = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
`ifdef AXI_BUSY_TRACKER_STATS_EN
  input  logic                stat_clr_i,
  output logic [31:0]         stat_wr_done_o,
  output logic [31:0]         stat_rd_done_o,
`endif
  input  logic [NumPorts-1:0] aw_sync_i,
  input  logic [NumPorts-1:0] b_sync_i,
  input  logic [NumPorts-1:0] ar_sync_i,
  input  logic [NumPorts-1:0] r_last_sync_i,
  output logic [NumPorts-1:0] aw_allow_o,
  output logic [NumPorts-1:0] ar_allow_o,
  output logic [NumPorts-1:0] port_busy_o,
  output logic                busy_o,
  input  logic                drain_req_i,
  output logic                drain_ack_o,
  output logic                err_o
);

  localparam int unsigned MaxOut = (MaxWrOutstanding > MaxRdOutstanding) ?
                                   MaxWrOutstanding : MaxRdOutstanding;
  localparam int unsigned CntW   = $clog2(MaxOut + 1);
  localparam int unsigned IdleW  = $clog2(IdleHoldCycles + 2);

  localparam logic [CntW-1:0]  WrLim   = CntW'(MaxWrOutstanding);
  localparam logic [CntW-1:0]  RdLim   = CntW'(MaxRdOutstanding);
  localparam logic [CntW-1:0]  CntMax  = '1;
  localparam logic [CntW-1:0]  CntOne  = CntW'(1);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(IdleHoldCycles);
  localparam logic [IdleW-1:0] IdleOne = IdleW'(1);

  typedef enum logic [1:0] {StRun, StDrain, StQuiesced} state_e;

  state_e                           state_q, state_d;
  logic [NumPorts-1:0][CntW-1:0]    wr_cnt_q, wr_cnt_d;
  logic [NumPorts-1:0][CntW-1:0]    rd_cnt_q, rd_cnt_d;
  logic [IdleW-1:0]                 idle_cnt_q, idle_cnt_d;
  logic [NumPorts-1:0]              aw_allow_q, aw_allow_d;
  logic [NumPorts-1:0]              ar_allow_q, ar_allow_d;
  logic [NumPorts-1:0]              port_busy_q, port_busy_d;
  logic                             busy_q, busy_d;
  logic                             ack_q, err_q, err_d;
  logic                             any_in, all_zero_q, all_zero_d, idle;

  always_comb begin
    err_d    = 1'b0;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    any_in   = (|aw_sync_i) | (|ar_sync_i);
    for (int unsigned p = 0; p < NumPorts; p++) begin
      // Requests beyond the limit or outside RUN are still counted so the B/R returns balance.
      if (aw_sync_i[p] && (wr_cnt_q[p] >= WrLim || state_q != StRun)) err_d = 1'b1;
      if (aw_sync_i[p] && !b_sync_i[p]) begin
        if (wr_cnt_q[p] != CntMax) wr_cnt_d[p] = wr_cnt_q[p] + CntOne;
      end else if (!aw_sync_i[p] && b_sync_i[p]) begin
        if (wr_cnt_q[p] == '0) err_d = 1'b1;
        else                   wr_cnt_d[p] = wr_cnt_q[p] - CntOne;
      end

      if (ar_sync_i[p] && (rd_cnt_q[p] >= RdLim || state_q != StRun)) err_d = 1'b1;
      if (ar_sync_i[p] && !r_last_sync_i[p]) begin
        if (rd_cnt_q[p] != CntMax) rd_cnt_d[p] = rd_cnt_q[p] + CntOne;
      end else if (!ar_sync_i[p] && r_last_sync_i[p]) begin
        if (rd_cnt_q[p] == '0) err_d = 1'b1;
        else                   rd_cnt_d[p] = rd_cnt_q[p] - CntOne;
      end
    end

    all_zero_q = (wr_cnt_q == '0) && (rd_cnt_q == '0);
    all_zero_d = (wr_cnt_d == '0) && (rd_cnt_d == '0);

    case (state_q)
      StRun:   state_d = drain_req_i ? StDrain : StRun;
      StDrain, StQuiesced: begin
        if (!drain_req_i)    state_d = StRun;
        else if (all_zero_d) state_d = StQuiesced;
        else                 state_d = StDrain;
      end
      default: state_d = StRun;
    endcase

    for (int unsigned p = 0; p < NumPorts; p++) begin
      aw_allow_d[p]  = (state_d == StRun) && (wr_cnt_d[p] < WrLim);
      ar_allow_d[p]  = (state_d == StRun) && (rd_cnt_d[p] < RdLim);
      port_busy_d[p] = (wr_cnt_d[p] != '0) || (rd_cnt_d[p] != '0);
    end

    // Idle timer counts cycles with all counters empty and no new request.
    idle       = all_zero_q && !any_in;
    idle_cnt_d = '0;
    if (idle) idle_cnt_d = (idle_cnt_q == IdleMax) ? idle_cnt_q : idle_cnt_q + IdleOne;
    busy_d = busy_q;
    if (any_in) busy_d = 1'b1;
    else if (idle && (32'(idle_cnt_q) + 32'd1 >= IdleHoldCycles)) busy_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StRun;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      idle_cnt_q  <= '0;
      aw_allow_q  <= '1;
      ar_allow_q  <= '1;
      port_busy_q <= '0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      aw_allow_q  <= aw_allow_d;
      ar_allow_q  <= ar_allow_d;
      port_busy_q <= port_busy_d;
      busy_q      <= busy_d;
      ack_q       <= (state_d == StQuiesced);
      err_q       <= err_d;
    end
  end

  assign aw_allow_o  = aw_allow_q;
  assign ar_allow_o  = ar_allow_q;
  assign port_busy_o = port_busy_q;
  assign busy_o      = busy_q;
  assign drain_ack_o = ack_q;
  assign err_o       = err_q;

`ifdef AXI_BUSY_TRACKER_STATS_EN
  logic [31:0] stat_wr_q, stat_wr_d, stat_rd_q, stat_rd_d;

  always_comb begin
    stat_wr_d = stat_wr_q;
    stat_rd_d = stat_rd_q;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      stat_wr_d = stat_wr_d + 32'(b_sync_i[p]);
      stat_rd_d = stat_rd_d + 32'(r_last_sync_i[p]);
    end
    if (stat_clr_i) begin
      stat_wr_d = '0;
      stat_rd_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_wr_q <= '0;
      stat_rd_q <= '0;
    end else begin
      stat_wr_q <= stat_wr_d;
      stat_rd_q <= stat_rd_d;
    end
  end

  assign stat_wr_done_o = stat_wr_q;
  assign stat_rd_done_o = stat_rd_q;
`endif

endmodule

// File: tb/tb_axi_multi_port_busy_tracker.sv
// Self-checking bench for axi_multi_port_busy_tracker: directed scenarios plus randomized traffic
// checked against a counting reference model.
module tb_axi_multi_port_busy_tracker;

  localparam int NP   = 2;
  localparam int MW   = 8;
  localparam int MR   = 8;
  localparam int HOLD = 4;
  localparam int CW   = $clog2(((MW > MR) ? MW : MR) + 1);
  localparam int CAP  = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [NP-1:0] aw_sync_i = '0, b_sync_i = '0, ar_sync_i = '0, r_last_sync_i = '0;
  logic [NP-1:0] aw_allow_o, ar_allow_o, port_busy_o;
  logic          busy_o, drain_req_i = 1'b0, drain_ack_o, err_o;
`ifdef AXI_BUSY_TRACKER_STATS_EN
  logic          stat_clr_i = 1'b0;
  logic [31:0]   stat_wr_done_o, stat_rd_done_o;
  logic [31:0]   m_stat_wr, m_stat_rd;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state: plain outstanding counts and a consecutive-idle run length.
  int            m_wr[NP], m_rd[NP];
  int            m_st;  // 0 run, 1 drain, 2 quiesced
  int            m_idle_run;
  bit            m_had, m_busy, m_err, m_ack;
  logic [NP-1:0] m_aw_allow, m_ar_allow, m_port_busy;

  axi_multi_port_busy_tracker #(
    .NumPorts(NP), .MaxWrOutstanding(MW), .MaxRdOutstanding(MR), .IdleHoldCycles(HOLD)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
`ifdef AXI_BUSY_TRACKER_STATS_EN
    .stat_clr_i(stat_clr_i),
    .stat_wr_done_o(stat_wr_done_o),
    .stat_rd_done_o(stat_rd_done_o),
`endif
    .aw_sync_i(aw_sync_i),
    .b_sync_i(b_sync_i),
    .ar_sync_i(ar_sync_i),
    .r_last_sync_i(r_last_sync_i),
    .aw_allow_o(aw_allow_o),
    .ar_allow_o(ar_allow_o),
    .port_busy_o(port_busy_o),
    .busy_o(busy_o),
    .drain_req_i(drain_req_i),
    .drain_ack_o(drain_ack_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_wr[p] = 0;
      m_rd[p] = 0;
    end
    m_st = 0; m_idle_run = 0; m_had = 0; m_busy = 0; m_err = 0; m_ack = 0;
    m_aw_allow = '1; m_ar_allow = '1; m_port_busy = '0;
`ifdef AXI_BUSY_TRACKER_STATS_EN
    m_stat_wr = '0; m_stat_rd = '0;
`endif
  endtask

  task automatic model_step();
    bit run, any_in, zero_before, zero_after, err;
    run = (m_st == 0);
    any_in = (|aw_sync_i) || (|ar_sync_i);
    zero_before = 1; zero_after = 1; err = 0;
    for (int p = 0; p < NP; p++) if (m_wr[p] != 0 || m_rd[p] != 0) zero_before = 0;
    for (int p = 0; p < NP; p++) begin
      if (aw_sync_i[p] && (m_wr[p] >= MW || !run)) err = 1;
      if (aw_sync_i[p] && !b_sync_i[p]) m_wr[p] = (m_wr[p] < CAP) ? m_wr[p] + 1 : m_wr[p];
      else if (!aw_sync_i[p] && b_sync_i[p]) begin
        if (m_wr[p] == 0) err = 1; else m_wr[p]--;
      end
      if (ar_sync_i[p] && (m_rd[p] >= MR || !run)) err = 1;
      if (ar_sync_i[p] && !r_last_sync_i[p]) m_rd[p] = (m_rd[p] < CAP) ? m_rd[p] + 1 : m_rd[p];
      else if (!ar_sync_i[p] && r_last_sync_i[p]) begin
        if (m_rd[p] == 0) err = 1; else m_rd[p]--;
      end
      if (m_wr[p] != 0 || m_rd[p] != 0) zero_after = 0;
    end
    if (m_st == 0) m_st = drain_req_i ? 1 : 0;
    else           m_st = !drain_req_i ? 0 : (zero_after ? 2 : 1);
    if (zero_before && !any_in) m_idle_run++; else m_idle_run = 0;
    if (any_in) m_had = 1;
    m_busy = m_had && (any_in || m_idle_run < HOLD);
    m_err  = err;
    m_ack  = (m_st == 2);
    for (int p = 0; p < NP; p++) begin
      m_aw_allow[p]  = (m_st == 0) && (m_wr[p] < MW);
      m_ar_allow[p]  = (m_st == 0) && (m_rd[p] < MR);
      m_port_busy[p] = (m_wr[p] != 0) || (m_rd[p] != 0);
    end
`ifdef AXI_BUSY_TRACKER_STATS_EN
    if (stat_clr_i) begin
      m_stat_wr = '0; m_stat_rd = '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        m_stat_wr = m_stat_wr + 32'(b_sync_i[p]);
        m_stat_rd = m_stat_rd + 32'(r_last_sync_i[p]);
      end
    end
`endif
  endtask

  // Applies one cycle of inputs, advances the model on the edge, returns 1 time unit after it.
  task automatic cycle(input logic [NP-1:0] aw, input logic [NP-1:0] b, input logic [NP-1:0] ar,
                       input logic [NP-1:0] r, input logic req);
    aw_sync_i = aw; b_sync_i = b; ar_sync_i = ar; r_last_sync_i = r; drain_req_i = req;
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    aw_sync_i = '0; b_sync_i = '0; ar_sync_i = '0; r_last_sync_i = '0; drain_req_i = 1'b0;
`ifdef AXI_BUSY_TRACKER_STATS_EN
    stat_clr_i = 1'b0;
`endif
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    cycle(2'b11, 2'b00, 2'b01, 2'b00, 1'b1);
    rst_ni = 1'b0;
    #2;
    total++;
    if ({aw_allow_o, ar_allow_o, port_busy_o, busy_o, drain_ack_o, err_o} !== {4'b1111, 5'b0}) begin
      bad++;
      $display("FAIL reset_outputs: got aw=%b ar=%b pb=%b busy=%b ack=%b err=%b want aw=11 ar=11 pb=00 busy=0 ack=0 err=0",
               aw_allow_o, ar_allow_o, port_busy_o, busy_o, drain_ack_o, err_o);
    end
    do_reset();
  endtask

  task automatic test_single_write();
    do_reset();
    cycle(2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      total++;
      if (port_busy_o !== 2'b01 || busy_o !== 1'b1) begin
        bad++;
        $display("FAIL single_write_busy[%0d]: got pb=%b busy=%b want pb=01 busy=1", i, port_busy_o, busy_o);
      end
    end
    cycle(2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
    total++;
    if (port_busy_o !== 2'b00 || err_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL single_write_b: got pb=%b err=%b busy=%b want pb=00 err=0 busy=1", port_busy_o, err_o, busy_o);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      total++;
      if (busy_o !== (i == 3 ? 1'b0 : 1'b1)) begin
        bad++;
        $display("FAIL single_write_hold[%0d]: got busy=%b want %b", i, busy_o, (i == 3 ? 1'b0 : 1'b1));
      end
    end
  endtask

  task automatic test_limit();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(2'b10, 2'b00, 2'b00, 2'b00, 1'b0);
      total++;
      if (aw_allow_o[1] !== (i < 7) || aw_allow_o[0] !== 1'b1 || err_o !== 1'b0) begin
        bad++;
        $display("FAIL limit_fill[%0d]: got aw_allow=%b err=%b want aw_allow[1]=%b err=0",
                 i, aw_allow_o, err_o, (i < 7));
      end
    end
    cycle(2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
    total++;
    if (aw_allow_o[1] !== 1'b1) begin
      bad++;
      $display("FAIL limit_release: got aw_allow[1]=%b want 1", aw_allow_o[1]);
    end
    cycle(2'b10, 2'b00, 2'b00, 2'b00, 1'b0);
    total++;
    if (aw_allow_o[1] !== 1'b0 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL limit_refill: got aw_allow[1]=%b err=%b want 0 0", aw_allow_o[1], err_o);
    end
    cycle(2'b10, 2'b00, 2'b00, 2'b00, 1'b0);
    total++;
    if (err_o !== 1'b1) begin
      bad++;
      $display("FAIL limit_overrun_err: got err=%b want 1", err_o);
    end
    cycle(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    total++;
    if (err_o !== 1'b0 || aw_allow_o[1] !== 1'b0) begin
      bad++;
      $display("FAIL limit_err_pulse: got err=%b aw_allow[1]=%b want 0 0", err_o, aw_allow_o[1]);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
    cycle(2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
    total++;
    if (port_busy_o !== 2'b01 || busy_o !== 1'b1 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL simul_inout: got pb=%b busy=%b err=%b want 01 1 0", port_busy_o, busy_o, err_o);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
      total++;
      if (port_busy_o[0] !== (i < 2) || err_o !== 1'b0) begin
        bad++;
        $display("FAIL simul_count[%0d]: got pb0=%b err=%b want %b 0", i, port_busy_o[0], err_o, (i < 2));
      end
    end
  endtask

  task automatic test_underflow();
    do_reset();
    cycle(2'b00, 2'b00, 2'b00, 2'b01, 1'b0);
    total++;
    if (err_o !== 1'b1 || port_busy_o !== 2'b00 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL underflow_err: got err=%b pb=%b busy=%b want 1 00 0", err_o, port_busy_o, busy_o);
    end
    cycle(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    total++;
    if (err_o !== 1'b0 || ar_allow_o !== 2'b11 || port_busy_o !== 2'b00) begin
      bad++;
      $display("FAIL underflow_hold: got err=%b ar_allow=%b pb=%b want 0 11 00", err_o, ar_allow_o, port_busy_o);
    end
  endtask

  task automatic test_drain();
    do_reset();
    cycle(2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
    cycle(2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
    cycle(2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
    total++;
    if (aw_allow_o !== 2'b00 || ar_allow_o !== 2'b00 || drain_ack_o !== 1'b0) begin
      bad++;
      $display("FAIL drain_allows: got aw=%b ar=%b ack=%b want 00 00 0", aw_allow_o, ar_allow_o, drain_ack_o);
    end
    cycle(2'b00, 2'b00, 2'b00, 2'b01, 1'b1);
    total++;
    if (drain_ack_o !== 1'b0) begin
      bad++;
      $display("FAIL drain_early_ack: got ack=%b want 0", drain_ack_o);
    end
    cycle(2'b00, 2'b00, 2'b00, 2'b01, 1'b1);
    total++;
    if (drain_ack_o !== 1'b1 || ar_allow_o !== 2'b00) begin
      bad++;
      $display("FAIL drain_ack: got ack=%b ar=%b want 1 00", drain_ack_o, ar_allow_o);
    end
    cycle(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    total++;
    if (drain_ack_o !== 1'b0 || aw_allow_o !== 2'b11 || ar_allow_o !== 2'b11) begin
      bad++;
      $display("FAIL drain_release: got ack=%b aw=%b ar=%b want 0 11 11", drain_ack_o, aw_allow_o, ar_allow_o);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
      total++;
      if (drain_ack_o !== (i == 1)) begin
        bad++;
        $display("FAIL drain_idle_ack[%0d]: got ack=%b want %b", i, drain_ack_o, (i == 1));
      end
    end
    cycle(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
  endtask

`ifdef AXI_BUSY_TRACKER_STATS_EN
  task automatic test_stats();
    do_reset();
    cycle(2'b00, 2'b11, 2'b00, 2'b00, 1'b0);
    cycle(2'b00, 2'b11, 2'b00, 2'b00, 1'b0);
    cycle(2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
    total++;
    if (stat_wr_done_o !== 32'd5 || stat_rd_done_o !== 32'd0) begin
      bad++;
      $display("FAIL stats_count: got wr=%0d rd=%0d want 5 0", stat_wr_done_o, stat_rd_done_o);
    end
    stat_clr_i = 1'b1;
    cycle(2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
    stat_clr_i = 1'b0;
    total++;
    if (stat_wr_done_o !== 32'd0) begin
      bad++;
      $display("FAIL stats_clear: got wr=%0d want 0", stat_wr_done_o);
    end
    cycle(2'b00, 2'b00, 2'b00, 2'b11, 1'b0);
    total++;
    if (stat_rd_done_o !== 32'd2 || stat_wr_done_o !== 32'd0) begin
      bad++;
      $display("FAIL stats_rd: got rd=%0d wr=%0d want 2 0", stat_rd_done_o, stat_wr_done_o);
    end
  endtask
`endif

  task automatic test_random();
    logic [NP-1:0] aw, b, ar, r;
    logic          req;
    do_reset();
    req = 1'b0;
    for (int n = 0; n < 800; n++) begin
      for (int p = 0; p < NP; p++) begin
        aw[p] = ($urandom_range(0, 9) < 3);
        b[p]  = ($urandom_range(0, 9) < 3);
        ar[p] = ($urandom_range(0, 9) < 3);
        r[p]  = ($urandom_range(0, 9) < 3);
      end
      if ($urandom_range(0, 39) == 0) req = ~req;
`ifdef AXI_BUSY_TRACKER_STATS_EN
      stat_clr_i = ($urandom_range(0, 49) == 0);
`endif
      cycle(aw, b, ar, r, req);
      total++;
      if (aw_allow_o !== m_aw_allow || ar_allow_o !== m_ar_allow) begin
        bad++;
        $display("FAIL rand_allow[%0d]: got aw=%b ar=%b want aw=%b ar=%b",
                 n, aw_allow_o, ar_allow_o, m_aw_allow, m_ar_allow);
      end
      total++;
      if (port_busy_o !== m_port_busy || busy_o !== m_busy) begin
        bad++;
        $display("FAIL rand_busy[%0d]: got pb=%b busy=%b want pb=%b busy=%b",
                 n, port_busy_o, busy_o, m_port_busy, m_busy);
      end
      total++;
      if (err_o !== m_err || drain_ack_o !== m_ack) begin
        bad++;
        $display("FAIL rand_err_ack[%0d]: got err=%b ack=%b want err=%b ack=%b",
                 n, err_o, drain_ack_o, m_err, m_ack);
      end
`ifdef AXI_BUSY_TRACKER_STATS_EN
      total++;
      if (stat_wr_done_o !== m_stat_wr || stat_rd_done_o !== m_stat_rd) begin
        bad++;
        $display("FAIL rand_stats[%0d]: got wr=%0d rd=%0d want wr=%0d rd=%0d",
                 n, stat_wr_done_o, stat_rd_done_o, m_stat_wr, m_stat_rd);
      end
`endif
    end
`ifdef AXI_BUSY_TRACKER_STATS_EN
    stat_clr_i = 1'b0;
`endif
    // Let everything quiesce so busy must fall through the hold window.
    for (int n = 0; n < 40; n++) begin
      cycle('0, '1, '0, '1, 1'b0);
    end
    total++;
    if (busy_o !== 1'b0 || port_busy_o !== 2'b00 || busy_o !== m_busy) begin
      bad++;
      $display("FAIL rand_settle: got busy=%b pb=%b want busy=0 pb=00", busy_o, port_busy_o);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_write();
    test_limit();
    test_simultaneous();
    test_underflow();
    test_drain();
`ifdef AXI_BUSY_TRACKER_STATS_EN
    test_stats();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
